signed_sat_accumulator: RTL and testbench



---
 rtl/signed_sat_accumulator.sv | 138 +++++++++++++
 tb/tb_signed_sat_accumulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator
//
// Purpose:
//   Sums a frame of COUNT signed two's-complement samples into a wider
//   signed accumulator. Every addition is clamped to the accumulator range
//   as it happens, so the order of the samples affects the result. A sticky
//   flag records whether any step of the frame was clamped. The finished
//   total is offered on a valid/ready output and held until it is taken.
//
// Parameters:
//   WIDTH  input sample width (signed)
//   ACC_W  accumulator / output width (signed), ACC_W >= WIDTH
//   COUNT  samples per frame, COUNT >= 1
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   sample present on in_data
//   in_ready   block accepts a sample (accumulating)
//   in_data    signed sample
//   in_flush   (SIGNED_SAT_ACC_FLUSH_EN only) close the frame after this sample
//   out_valid  frame total available
//   out_ready  downstream takes the total
//   out_data   signed saturated frame total, 0 when out_valid is low
//   out_sat    some step of this frame saturated, 0 when out_valid is low
//
// Optional feature macro: SIGNED_SAT_ACC_FLUSH_EN adds the in_flush port.

module signed_sat_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 5,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef SIGNED_SAT_ACC_FLUSH_EN
  input  logic             in_flush,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;

  logic             in_hs;
  logic             out_hs;
  logic             flush_req;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;

`ifdef SIGNED_SAT_ACC_FLUSH_EN
  assign flush_req = in_flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == HOLD);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Both operands fit in ACC_W signed bits, so the ACC_W+1 bit sum is exact;
  // it is out of range exactly when its top two bits disagree, and the top
  // bit then gives the direction of the overflow.
  assign sum     = {acc_reg[ACC_W-1], acc_reg}
                 + {{(ACC_W+1-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

  // Result is gated to zero outside HOLD so downstream never sees a
  // partial total.
  assign out_data = out_valid ? acc_reg : '0;
  assign out_sat  = out_valid && sat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      sat_reg   <= sat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    sat_next   = sat_reg;
    case (state_reg)
      ACCUM: begin
        if (in_hs) begin
          if (sum_ovf) begin
            acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_next = 1'b1;
          end else begin
            acc_next = sum[ACC_W-1:0];
          end
          cnt_next = cnt_reg + CNT_W'(1);
          if ((cnt_reg == LAST_CNT) || flush_req) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_hs) begin
          acc_next   = '0;
          cnt_next   = '0;
          sat_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
module tb_signed_sat_accumulator;

  localparam int MAXV = 15;
  localparam int MINV = -16;

  typedef struct packed {
    logic [4:0] data;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_sat;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  signed_sat_accumulator #(.WIDTH(4), .ACC_W(5), .COUNT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef SIGNED_SAT_ACC_FLUSH_EN
    .in_flush (in_flush),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: clamp after every step, n samples taken from a..d.
  task automatic push_exp(input int a, input int b, input int c, input int d, input int n);
    int   s[4];
    int   acc;
    int   nx;
    logic sat;
    exp_t e;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      nx = acc + s[i];
      if (nx > MAXV) begin
        acc = MAXV; sat = 1'b1;
      end else if (nx < MINV) begin
        acc = MINV; sat = 1'b1;
      end else begin
        acc = nx;
      end
    end
    e.data = acc[4:0];
    e.sat  = sat;
    exp_q.push_back(e);
  endtask

  // One sample: wait (bounded) for in_ready, present it across one rising edge.
  task automatic send(input int v, input logic f);
    int tries;
    tries = 0;
    @(negedge clk);
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = v[3:0];
    in_flush = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  // Full frame; out_valid must be up the cycle after the last handshake.
  task automatic frame(input int a, input int b, input int c, input int d);
    push_exp(a, b, c, d, 4);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
    @(negedge clk);
    chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
  endtask

  // Called on a negedge; compares the offered total and completes the handshake.
  task automatic collect();
    exp_t e;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_data", {27'b0, out_data}, {27'b0, e.data});
      chk("out_sat", {31'b0, out_sat}, {31'b0, e.sat});
      $display("frame out_data=%0d out_sat=%0b expected %0d/%0b",
               $signed(out_data), out_sat, $signed(e.data), e.sat);
    end else begin
      chk("unexpected_output", {31'b0, out_valid}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_out", {31'b0, in_ready}, 32'd1);
    chk("out_data_idle", {27'b0, out_data}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {27'b0, out_data}, 32'd0);
    chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
    rst = 1'b0;

    // Plain frame, positive saturation, negative saturation, order dependence.
    frame(3, -2, 5, -1);  collect();
    frame(7, 7, 7, 7);    collect();
    frame(-8, -8, -8, -8); collect();
    frame(7, 7, 7, -8);   collect();

    // Backpressure: result held for 5 cycles, stray input ignored.
    out_ready = 1'b0;
    frame(2, 2, 2, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd7;
      chk("stall_out_data", {27'b0, out_data}, 32'd8);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect();
    frame(-3, -3, -3, -3); collect();

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    frame(7, 7, 7, 7);
    #2 rst = 1'b1;
    #1;
    chk("hold_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_rst_out_data", {27'b0, out_data}, 32'd0);
    chk("hold_rst_out_sat", {31'b0, out_sat}, 32'd0);
    chk("hold_rst_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Reset mid-frame discards the partial sum.
    send(2, 1'b0);
    send(3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(1, 1, 1, 1); collect();

`ifdef SIGNED_SAT_ACC_FLUSH_EN
    push_exp(6, -1, 0, 0, 2);
    send(6, 1'b0);
    send(-1, 1'b1);
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd1);
    collect();
    frame(1, 2, 3, 4); collect();
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
